// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define EX_MULDIV_SIGNED_EN to build signed MULT/DIV; otherwise they alias MULTU/DIVU.
module ex_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIN
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   m1, m2;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] mul_nx;
  logic [WIDTH:0]     rem_sh;
  logic               ge;
  logic [WIDTH-1:0]   r_new;
  logic [2*WIDTH-1:0] div_nx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

`ifdef EX_MULDIV_SIGNED_EN
  logic neg_q, neg_d;
  logic negr_q, negr_d;
  logic sgn, s1, s2;
`endif

  // Operand magnitudes; signed ops run unsigned and fix signs at the end
  always_comb begin
`ifdef EX_MULDIV_SIGNED_EN
    sgn = ~mdop[2] & ~mdop[0];
    s1  = sgn & Rdata1[WIDTH-1];
    s2  = sgn & Rdata2[WIDTH-1];
    m1  = s1 ? -Rdata1 : Rdata1;
    m2  = s2 ? -Rdata2 : Rdata2;
`else
    m1  = Rdata1;
    m2  = Rdata2;
`endif
  end

  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
    mul_nx = p_q[0] ? {sum, p_q[WIDTH-1:1]}
                    : {1'b0, p_q[2*WIDTH-1:1]};
    rem_sh = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    ge     = rem_sh >= {1'b0, a_q};
    r_new  = ge ? (rem_sh[WIDTH-1:0] - a_q) : rem_sh[WIDTH-1:0];
    div_nx = {r_new, p_q[WIDTH-2:0], ge};
    prod   = mul_nx;
    quo    = div_nx[WIDTH-1:0];
    rem    = div_nx[2*WIDTH-1:WIDTH];
`ifdef EX_MULDIV_SIGNED_EN
    if (neg_q) begin
      prod = -mul_nx;
      quo  = -div_nx[WIDTH-1:0];
    end
    if (negr_q) rem = -div_nx[2*WIDTH-1:WIDTH];
`endif
  end

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    a_d     = a_q;
    p_d     = p_q;
`ifdef EX_MULDIV_SIGNED_EN
    neg_d   = neg_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (mdop)
            3'd0, 3'd1: begin
              state_d = MUL;
              busy_d  = 1'b1;
              cnt_d   = '0;
              a_d     = m1;
              p_d     = {{WIDTH{1'b0}}, m2};
`ifdef EX_MULDIV_SIGNED_EN
              neg_d   = s1 ^ s2;
`endif
            end
            3'd2, 3'd3: begin
              busy_d = 1'b1;
              if (Rdata2 == '0) begin
                state_d = FIN;
                done_d  = 1'b1;
                dbz_d   = 1'b1;
                hi_d    = Rdata1;
                lo_d    = '1;
              end else begin
                state_d = DIV;
                cnt_d   = '0;
                a_d     = m2;
                p_d     = {{WIDTH{1'b0}}, m1};
`ifdef EX_MULDIV_SIGNED_EN
                neg_d   = s1 ^ s2;
                negr_d  = s1;
`endif
              end
            end
            3'd4:    hi_d = Rdata1;
            3'd5:    lo_d = Rdata1;
            default: ;
          endcase
        end
      end
      MUL: begin
        p_d   = mul_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d      = FIN;
          done_d       = 1'b1;
          {hi_d, lo_d} = prod;
        end
      end
      DIV: begin
        p_d   = div_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = FIN;
          done_d  = 1'b1;
          hi_d    = rem;
          lo_d    = quo;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      a_q     <= '0;
      p_q     <= '0;
`ifdef EX_MULDIV_SIGNED_EN
      neg_q   <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      a_q     <= a_d;
      p_q     <= p_d;
`ifdef EX_MULDIV_SIGNED_EN
      neg_q   <= neg_d;
      negr_q  <= negr_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: 32-bit instance plus a 16-bit instance for MTHI/MTLO.
module tb_ex_muldiv;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, start16;
  logic [2:0]  mdop, mdop16;
  logic [31:0] r1, r2, hi, lo;
  logic [15:0] r1_16, r2_16, hi16, lo16;
  logic        busy, done, dbz;
  logic        busy16, done16, dbz16;

  int npass = 0;
  int ntot  = 0;

  always #5 CLK = ~CLK;

  ex_muldiv #(.WIDTH(32), .CNT_W(6)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .mdop(mdop),
    .Rdata1(r1), .Rdata2(r2), .busy(busy), .done(done),
    .dbz(dbz), .hi(hi), .lo(lo)
  );

  ex_muldiv #(.WIDTH(16), .CNT_W(5)) u_dut16 (
    .CLK(CLK), .RST(RST), .start(start16), .mdop(mdop16),
    .Rdata1(r1_16), .Rdata2(r2_16), .busy(busy16), .done(done16),
    .dbz(dbz16), .hi(hi16), .lo(lo16)
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one op and wait for done; lat counts edges from the start edge.
  // inj > 0 raises an MTHI 5 request at that cycle, which must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj,
                        output int lat, output logic dz,
                        output logic hb);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; hb = 1'b0; dz = 1'b0;
    start = 1'b1; mdop = op; r1 = a; r2 = b;
    step;
    lat = 1;
    start = 1'b0;
    while (!done && lat < 100) begin
      if (hi !== h0 || lo !== l0 || busy !== 1'b1) hb = 1'b1;
      if (lat == inj) begin
        start = 1'b1; mdop = 3'd4; r1 = 32'd5;
      end else begin
        start = 1'b0;
      end
      step;
      lat++;
    end
    start = 1'b0;
    dz = dbz;
  endtask

  int   lat;
  logic dz, hb;
  int   ndone;

  initial begin
    RST = 1'b1; start = 1'b0; mdop = '0; r1 = '0; r2 = '0;
    start16 = 1'b0; mdop16 = '0; r1_16 = '0; r2_16 = '0;
    step; step;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    RST = 1'b0;

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, dz, hb);
    chk("multu_lat", lat, 33);
    chk("multu_hi", hi, 64'hFFFFFFFE);
    chk("multu_lo", lo, 64'h1);
    chk("multu_busy_at_done", busy, 1);
    chk("multu_dbz", dz, 0);
    chk("multu_hold", hb, 0);
    step;
    chk("multu_done_clr", done, 0);
    chk("multu_busy_clr", busy, 0);

    run_op(3'd3, 32'd100, 32'd0, 0, lat, dz, hb);
    chk("dbz_lat", lat, 1);
    chk("dbz_flag", dz, 1);
    chk("dbz_busy", busy, 1);
    chk("dbz_hi", hi, 64'd100);
    chk("dbz_lo", lo, 64'hFFFFFFFF);
    step;
    chk("dbz_busy_clr", busy, 0);
    chk("dbz_flag_clr", dbz, 0);

    run_op(3'd3, 32'd100, 32'd7, 3, lat, dz, hb);
    chk("divu_lat", lat, 33);
    chk("divu_hi", hi, 64'd2);
    chk("divu_lo", lo, 64'd14);
    chk("divu_dbz", dz, 0);
    chk("divu_ignore_hold", hb, 0);
    step;

    run_op(3'd1, 32'h00010000, 32'h00010000, 0, lat, dz, hb);
    chk("multu2_hi", hi, 64'h1);
    chk("multu2_lo", lo, 64'h0);
    step;

    run_op(3'd3, 32'hFFFFFFFF, 32'd1, 0, lat, dz, hb);
    chk("divu1_hi", hi, 64'h0);
    chk("divu1_lo", lo, 64'hFFFFFFFF);
    step;

`ifdef EX_MULDIV_SIGNED_EN
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, lat, dz, hb);
    chk("mult_hi", hi, 64'hFFFFFFFF);
    chk("mult_lo", lo, 64'hFFFFFFEB);
    step;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, lat, dz, hb);
    chk("div_lat", lat, 33);
    chk("div_lo", lo, 64'hFFFFFFFD);
    chk("div_hi", hi, 64'hFFFFFFFF);
    step;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, lat, dz, hb);
    chk("divmin_lo", lo, 64'h80000000);
    chk("divmin_hi", hi, 64'h0);
    chk("divmin_dbz", dz, 0);
    step;
`else
    run_op(3'd0, 32'hFFFFFFFD, 32'd7, 0, lat, dz, hb);
    chk("mult_u_hi", hi, 64'h6);
    chk("mult_u_lo", lo, 64'hFFFFFFEB);
    step;
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, lat, dz, hb);
    chk("div_u_lat", lat, 33);
    chk("div_u_lo", lo, 64'h7FFFFFFC);
    chk("div_u_hi", hi, 64'h1);
    step;
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, lat, dz, hb);
    chk("divmin_u_lo", lo, 64'h0);
    chk("divmin_u_hi", hi, 64'h80000000);
    chk("divmin_u_dbz", dz, 0);
    step;
`endif

    start = 1'b1; mdop = 3'd1; r1 = 32'd3; r2 = 32'd5;
    step;
    start = 1'b0;
    repeat (9) step;
    chk("abort_busy_pre", busy, 1);
    RST = 1'b1;
    step;
    RST = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_done", done, 0);
    ndone = 0;
    repeat (40) begin
      step;
      if (done || busy) ndone++;
    end
    chk("abort_no_done", ndone, 0);

    start16 = 1'b1; mdop16 = 3'd5; r1_16 = 16'h1234;
    step;
    chk("mtlo16_lo", lo16, 64'h1234);
    chk("mtlo16_busy", busy16, 0);
    chk("mtlo16_done", done16, 0);
    mdop16 = 3'd4; r1_16 = 16'hABCD;
    step;
    start16 = 1'b0;
    chk("mthi16_hi", hi16, 64'hABCD);
    chk("mthi16_lo", lo16, 64'h1234);
    chk("mthi16_busy", busy16, 0);
    chk("mthi16_done", done16, 0);
    step;
    chk("mt16_done_after", done16, 0);
    chk("mt16_busy_after", busy16, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
